// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, status flag
// bit positions and the opcode values the companion ALU understands.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside the {N,Z,C,V} status register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes are only interpreted by the ALU; the sequencer passes them through.
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external combinational ALU,
// holding its inputs stable, capturing the result and maintaining {N,Z,C,V}.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the source holds valid and its payload steady until that edge.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_use_carry,
    input  logic             in_set_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       flags,
    output state_e           dbg_state_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             cin_q, cin_d;
    logic             set_flags_q, set_flags_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cin_d       = cin_q;
        set_flags_d = set_flags_q;
        y_d         = y_q;
        flags_d     = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    op_d        = in_op;
                    set_flags_d = in_set_flags;
                    // Carry-in uses the flag value from before this accept.
                    cin_d       = in_use_carry & flags_q[FLAG_C];
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d = alu_y;
                if (set_flags_q) begin
                    flags_d = {alu_n, alu_z, alu_c, alu_v};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cin_q       <= 1'b0;
            set_flags_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cin_q       <= cin_d;
            set_flags_q <= set_flags_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign alu_cin     = cin_q;
    assign out_y       = y_q;
    assign flags       = flags_q;
    assign dbg_state_o = state_q;

endmodule
